clkdiv_prog: RTL and testbench

- Runtime-programmable, parametrised successor to the fixed clock divider.
- Produces a 50%-duty divided clock, `clk_div`, from `clk`. The half-period is loaded at run time through a load/ack handshake.
- Ratio changes apply glitch-free at half-period boundaries.
- Start/stop is controlled by `en`, with drain-to-low on stop.
- Sits between the system clock and slow peripherals such as the counter, scan and debounce blocks.

---
 rtl/clkdiv_prog_if.sv | 27 ++
 rtl/clkdiv_prog.sv | 150 +++++++++++++++
 tb/tb_clkdiv_prog.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_prog_if.sv
// Purpose : control/status bundle for the programmable clock divider.
// Latency : n/a (signal grouping only).
// Backpr. : none; div_ld is a fire-and-forget strobe, div_ack reports when it takes effect.
//
// Signals: en (run request), div_ld/div_in (half-period load strobe and value),
// div_ack (load became active), clk_div (divided clock), running (RUN or DRAIN),
// tick (rise-coincident enable pulse, only with CLKDIV_PROG_TICK_EN defined).
// master = controller side, slave = divider side.
interface clkdiv_prog_if #(
   parameter int DIV_W = 16
);
   logic             en;
   logic             div_ld;
   logic [DIV_W-1:0] div_in;
   logic             div_ack;
   logic             clk_div;
   logic             running;
`ifdef CLKDIV_PROG_TICK_EN
   logic             tick;

   modport master (output en, div_ld, div_in, input div_ack, clk_div, running, tick);
   modport slave  (input en, div_ld, div_in, output div_ack, clk_div, running, tick);
`else
   modport master (output en, div_ld, div_in, input div_ack, clk_div, running);
   modport slave  (input en, div_ld, div_in, output div_ack, clk_div, running);
`endif
endinterface

// File: rtl/clkdiv_prog.sv
// Purpose : runtime-programmable 50%-duty clock divider, glitch-free ratio change, drain-to-low stop.
// Latency : first clk_div rise H clk cycles after RUN entry; div_ack one cycle after the load takes effect.
// Backpr. : none; loads while running are held in a shadow (latest wins) until the next half-period boundary.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   bus (slave) en, div_ld, div_in -> div_ack, clk_div, running [, tick]
// Optional feature macro: CLKDIV_PROG_TICK_EN adds bus.tick, a registered pulse
// on every rising transition of clk_div.
// Parameters: DIV_W (counter/half-period width), DEFAULT_HALF (half-period after reset, >= 1).
module clkdiv_prog #(
   parameter int DIV_W        = 16,
   parameter int DEFAULT_HALF = 50
) (
   input  logic         clk,
   input  logic         rst,
   clkdiv_prog_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
   localparam logic [DIV_W-1:0] DEF_HALF = DIV_W'(DEFAULT_HALF);

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] active;
   logic [DIV_W-1:0] shadow;
   logic             pending;
   logic             clk_div_q;
   logic             div_ack_q;
   logic             running_q;

   logic [DIV_W-1:0] h_eff;
   logic             terminal;
   logic             ld_any;
   logic [DIV_W-1:0] ld_val;

   // A zero request would never reach terminal; clamp it to the minimum ratio.
   assign h_eff    = (bus.div_in == '0) ? ONE : bus.div_in;
   assign terminal = (cnt == (active - ONE));
   // A strobe arriving on a boundary cycle beats whatever is parked in the shadow.
   assign ld_any   = bus.div_ld | pending;
   assign ld_val   = bus.div_ld ? h_eff : shadow;

`ifdef CLKDIV_PROG_TICK_EN
   logic tick_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         active    <= DEF_HALF;
         shadow    <= '0;
         pending   <= 1'b0;
         clk_div_q <= 1'b0;
         div_ack_q <= 1'b0;
         running_q <= 1'b0;
`ifdef CLKDIV_PROG_TICK_EN
         tick_q    <= 1'b0;
`endif
      end else begin
         div_ack_q <= 1'b0;
`ifdef CLKDIV_PROG_TICK_EN
         tick_q    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               cnt       <= '0;
               clk_div_q <= 1'b0;
               pending   <= 1'b0;
               if (bus.div_ld) begin
                  active    <= h_eff;
                  div_ack_q <= 1'b1;
               end
               if (bus.en) begin
                  state     <= RUN;
                  running_q <= 1'b1;
               end
            end

            RUN, DRAIN: begin
               if (state == RUN && !bus.en && !clk_div_q) begin
                  // Output already low: stop at once, flushing any parked load.
                  state     <= IDLE;
                  running_q <= 1'b0;
                  cnt       <= '0;
                  if (ld_any) begin
                     active    <= ld_val;
                     pending   <= 1'b0;
                     div_ack_q <= 1'b1;
                  end
               end else if (terminal) begin
                  // Half-period boundary: the only place the ratio may change.
                  cnt <= '0;
                  if (ld_any) begin
                     active    <= ld_val;
                     pending   <= 1'b0;
                     div_ack_q <= 1'b1;
                  end
                  if (!bus.en && clk_div_q) begin
                     // High half completed while stopping: land low in IDLE.
                     clk_div_q <= 1'b0;
                     state     <= IDLE;
                     running_q <= 1'b0;
                  end else begin
                     clk_div_q <= ~clk_div_q;
                     state     <= RUN;
                     running_q <= 1'b1;
`ifdef CLKDIV_PROG_TICK_EN
                     tick_q    <= ~clk_div_q;
`endif
                  end
               end else begin
                  cnt       <= cnt + ONE;
                  running_q <= 1'b1;
                  if (bus.div_ld) begin
                     shadow  <= h_eff;
                     pending <= 1'b1;
                  end
                  // Reaching here with en low implies clk_div is high: hold it until terminal.
                  state <= bus.en ? RUN : DRAIN;
               end
            end

            default: begin
               state     <= IDLE;
               cnt       <= '0;
               clk_div_q <= 1'b0;
               running_q <= 1'b0;
               pending   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.clk_div = clk_div_q;
   assign bus.div_ack = div_ack_q;
   assign bus.running = running_q;
`ifdef CLKDIV_PROG_TICK_EN
   assign bus.tick    = tick_q;
`endif

endmodule

// File: tb/tb_clkdiv_prog.sv
// Purpose : directed self-checking bench for clkdiv_prog (DEFAULT_HALF=50, DIV_W=16).
// Latency : n/a.
// Backpr. : n/a.
module tb_clkdiv_prog;

   localparam int DIV_W = 16;
   localparam int LIMIT = 300;

   logic clk;
   logic rst;

   clkdiv_prog_if #(.DIV_W(DIV_W)) bus ();

   clkdiv_prog #(.DIV_W(DIV_W), .DEFAULT_HALF(50)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_chk;
   int   n_err;
   int   acks;
   int   rises;
   int   ticks;
   int   tick_bad;
   logic prev_div;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock, sampled at the falling edge; tallies acks, rises and tick alignment.
   task automatic step();
      @(negedge clk);
      if (bus.div_ack === 1'b1) acks++;
      if (bus.clk_div === 1'b1 && prev_div === 1'b0) rises++;
`ifdef CLKDIV_PROG_TICK_EN
      if (bus.tick === 1'b1) ticks++;
      if (bus.tick !== (bus.clk_div & ~prev_div)) tick_bad++;
`endif
      prev_div = bus.clk_div;
   endtask

   task automatic wait_level(input logic lvl, output int n);
      n = 0;
      while (bus.clk_div !== lvl && n < LIMIT) begin
         step();
         n++;
      end
   endtask

   // Counts samples at level lvl; optionally strobes loads at sample indices ld_a / ld_b.
   task automatic measure_half(input logic lvl, input int ld_a, input logic [DIV_W-1:0] va,
                               input int ld_b, input logic [DIV_W-1:0] vb, output int n);
      n = 0;
      while (bus.clk_div === lvl && n < LIMIT) begin
         bus.div_ld = (n == ld_a) || (n == ld_b);
         bus.div_in = (n == ld_b) ? vb : va;
         n++;
         step();
      end
      bus.div_ld = 1'b0;
   endtask

   task automatic do_reset();
      bus.en     = 1'b0;
      bus.div_ld = 1'b0;
      bus.div_in = '0;
      rst        = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic load_idle(input logic [DIV_W-1:0] v, input string tag);
      bus.div_ld = 1'b1;
      bus.div_in = v;
      step();
      bus.div_ld = 1'b0;
      check(tag, bus.div_ack, 1);
   endtask

   int n;
   int r0;

   initial begin
      n_chk = 0; n_err = 0; acks = 0; rises = 0; ticks = 0; tick_bad = 0;
      prev_div   = 1'b0;
      bus.en     = 1'b0;
      bus.div_ld = 1'b0;
      bus.div_in = '0;
      rst = 1'b1;
      #1 rst = 1'b0;

      // Reset state
      step();
      check("rst_clk_div", bus.clk_div, 0);
      check("rst_running", bus.running, 0);
      check("rst_div_ack", bus.div_ack, 0);
`ifdef CLKDIV_PROG_TICK_EN
      check("rst_tick", bus.tick, 0);
`endif
      step();
      rst = 1'b1;
      step();

      // Default half-period 50
      bus.en = 1'b1;
      wait_level(1'b1, n);
      check("def_first_rise", n, 51);
      check("def_running", bus.running, 1);
      measure_half(1'b1, -1, '0, -1, '0, n);
      check("def_high", n, 50);
      measure_half(1'b0, -1, '0, -1, '0, n);
      check("def_low", n, 50);

      // IDLE load of 5, then start
      do_reset();
      acks = 0;
      load_idle(16'd5, "idle_ack");
      bus.en = 1'b1;
      wait_level(1'b1, n);
      check("h5_first_rise", n, 6);
      measure_half(1'b1, -1, '0, -1, '0, n);
      check("h5_high", n, 5);
      measure_half(1'b0, -1, '0, -1, '0, n);
      check("h5_low", n, 5);
      check("idle_ack_count", acks, 1);

      // Reload 5 -> 3 during the high half
      acks = 0;
      measure_half(1'b1, 1, 16'd3, -1, '0, n);
      check("reload_cur_high", n, 5);
      check("reload_ack_timing", bus.div_ack, 1);
      measure_half(1'b0, -1, '0, -1, '0, n);
      check("reload_low", n, 3);
      measure_half(1'b1, -1, '0, -1, '0, n);
      check("reload_high", n, 3);
      check("reload_ack_count", acks, 1);

      // Two loads in one half: 7 then 4, latest wins
      acks = 0;
      measure_half(1'b0, 0, 16'd7, 1, 16'd4, n);
      check("dbl_cur_low", n, 3);
      check("dbl_ack_timing", bus.div_ack, 1);
      measure_half(1'b1, -1, '0, -1, '0, n);
      check("dbl_high", n, 4);
      measure_half(1'b0, -1, '0, -1, '0, n);
      check("dbl_low", n, 4);
      check("dbl_ack_count", acks, 1);

      // div_in=0 behaves as 1: period 2
      do_reset();
      load_idle(16'd0, "zero_ack");
      bus.en = 1'b1;
      wait_level(1'b1, n);
      check("h1_first_rise", n, 2);
      measure_half(1'b1, -1, '0, -1, '0, n);
      check("h1_high", n, 1);
      measure_half(1'b0, -1, '0, -1, '0, n);
      check("h1_low", n, 1);
      // Load on a terminal cycle applies at that same boundary
      measure_half(1'b1, 0, 16'd2, -1, '0, n);
      check("term_ld_high", n, 1);
      check("term_ld_ack", bus.div_ack, 1);
      measure_half(1'b0, -1, '0, -1, '0, n);
      check("term_ld_low", n, 2);
      measure_half(1'b1, -1, '0, -1, '0, n);
      check("term_ld_high2", n, 2);

      // Stop while high with H=6: drain the half, then idle low
      do_reset();
      load_idle(16'd6, "h6_ack");
      bus.en = 1'b1;
      wait_level(1'b1, n);
      check("h6_first_rise", n, 7);
      bus.en = 1'b0;
      step();
      check("drain_running", bus.running, 1);
      check("drain_clk_div", bus.clk_div, 1);
      measure_half(1'b1, -1, '0, -1, '0, n);
      check("drain_high_rest", n, 5);
      check("drain_end_running", bus.running, 0);
      r0 = rises;
      for (int i = 0; i < 20; i++) step();
      check("drain_no_rise", rises, r0);
      check("drain_idle_low", bus.clk_div, 0);

      // Stop while low: immediate idle, restart counts from zero
      do_reset();
      load_idle(16'd4, "h4_ack");
      bus.en = 1'b1;
      step();
      step();
      step();
      bus.en = 1'b0;
      step();
      check("low_stop_running", bus.running, 0);
      check("low_stop_clk_div", bus.clk_div, 0);
      bus.en = 1'b1;
      wait_level(1'b1, n);
      check("restart_first_rise", n, 5);

      // Asynchronous reset mid-run, between clock edges
      #2 rst = 1'b0;
      #1;
      check("async_rst_clk_div", bus.clk_div, 0);
      check("async_rst_running", bus.running, 0);
      bus.en = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("post_rst_clk_div", bus.clk_div, 0);

`ifdef CLKDIV_PROG_TICK_EN
      check("tick_align", tick_bad, 0);
      check("tick_per_rise", ticks, rises);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
